// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bus between two requesters and the regfile port arbiter.
// master = requester/decode side, slave = arbiter.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [63:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [63:0] rf_rd1;
  logic [63:0] rf_rd2;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic [15:0] conflict_cnt;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, ra1, ra2, rf_rd1, rf_rd2,
    input  a_ready, b_ready, we3, wa3, wd3, rd1, rd2, conflict_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, ra1, ra2, rf_rd1, rf_rd2,
    output a_ready, b_ready, we3, wa3, wd3, rd1, rd2, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester arbiter for the single regfile write port with XZR drop, B anti-starvation and read forwarding.
// Latency: grant same cycle, we3 one cycle later; ready is combinational, at most one requester accepted per cycle.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam logic [4:0] XZR   = 5'd31;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic [15:0] conflict_q;
  logic        we3_q;
  logic [4:0]  wa3_q;
  logic [63:0] wd3_q;
  logic        b_prio;
  logic        a_xfer;
  logic        b_xfer;

  assign b_prio = (starve_cnt >= LIMIT);
  assign b_xfer = !reset && bus.b_valid && (b_prio || !bus.a_valid);
  assign a_xfer = !reset && bus.a_valid && !(bus.b_valid && b_prio);

  assign bus.a_ready      = a_xfer;
  assign bus.b_ready      = b_xfer;
  assign bus.we3          = we3_q;
  assign bus.wa3          = wa3_q;
  assign bus.wd3          = wd3_q;
  assign bus.conflict_cnt = conflict_q;

  // XZR reads never forward: the regfile already returns zero for it.
  assign bus.rd1 = (we3_q && (wa3_q == bus.ra1) && (bus.ra1 != XZR)) ? wd3_q : bus.rf_rd1;
  assign bus.rd2 = (we3_q && (wa3_q == bus.ra2) && (bus.ra2 != XZR)) ? wd3_q : bus.rf_rd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      conflict_q <= 16'd0;
      we3_q      <= 1'b0;
      wa3_q      <= 5'd0;
      wd3_q      <= 64'd0;
    end else begin
      if (bus.b_valid && !b_xfer) begin
        if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end

      if (bus.a_valid && bus.b_valid && (conflict_q != 16'hFFFF))
        conflict_q <= conflict_q + 16'd1;

      we3_q <= 1'b0;
      if (a_xfer && (bus.a_addr != XZR)) begin
        we3_q <= 1'b1;
        wa3_q <= bus.a_addr;
        wd3_q <= bus.a_data;
      end else if (b_xfer && (bus.b_addr != XZR)) begin
        we3_q <= 1'b1;
        wa3_q <= bus.b_addr;
        wd3_q <= bus.b_data;
      end
    end
  end
endmodule
